// File: rtl/response_generator.sv
// response_generator: queues ACK/NAK requests and emits TYPE/EID/LEN/payload frames
// over a ready/valid byte stream.
module response_generator #(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             generate_ack,
  input  logic             generate_nak,
  input  logic [7:0]       eid_in,
  input  logic [7:0]       len_in,
  input  logic [7:0]       payload_data,
  input  logic             payload_valid,
  output logic             payload_ready,
  input  logic             message_ready,
  output logic [7:0]       message_data,
  output logic             message_data_valid,
  output logic             message_frame_valid,
  output logic [CNT_W-1:0] queue_count,
  output logic             queue_full,
  output logic             overflow,
  input  logic             overflow_clear
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  typedef enum logic [2:0] {IDLE, TYPE, EID, LEN, PAYLOAD} state_t;
  state_t state_q, state_d;
  logic [16:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic overflow_q, nak_q, req, push, pop;
  logic [7:0] eid_q, len_q, cnt_q, cnt_d;
  assign req = generate_ack | generate_nak;
  assign queue_full = count_q == CNT_W'(QUEUE_DEPTH);
  assign push = req & ~queue_full;
  assign pop = (state_q == IDLE) && (count_q != '0);
  assign queue_count = count_q;
  assign overflow = overflow_q;
  assign message_frame_valid = state_q != IDLE;
  // A simultaneous ACK+NAK collapses to a single ACK entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {generate_nak & ~generate_ack, eid_in, len_in};
    if (pop) {nak_q, eid_q, len_q} <= mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_q + PTR_W'(push);
      rd_q       <= rd_q + PTR_W'(pop);
      count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_q <= (req & queue_full) | (overflow_q & ~overflow_clear);
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    message_data = 8'h00;
    message_data_valid = 1'b0;
    payload_ready = 1'b0;
    case (state_q)
      IDLE: state_d = pop ? TYPE : IDLE;
      TYPE: begin
        message_data_valid = 1'b1;
        message_data = {7'b0, nak_q};
        state_d = message_ready ? EID : TYPE;
      end
      EID: begin
        message_data_valid = 1'b1;
        message_data = eid_q;
        state_d = message_ready ? LEN : EID;
      end
      LEN: begin
        message_data_valid = 1'b1;
        message_data = len_q;
        if (message_ready) begin
          state_d = (len_q == 8'd0) ? IDLE : PAYLOAD;
          cnt_d = len_q;
        end
      end
      PAYLOAD: begin
        payload_ready = message_ready;
        message_data_valid = payload_valid;
        message_data = payload_valid ? payload_data : 8'h00;
        if (payload_valid && message_ready) begin
          cnt_d = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? IDLE : PAYLOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_response_generator.sv
// tb_response_generator: scoreboard bench for response_generator; expected frame
// bytes are queued when requests are issued and popped on every accepted byte.
module tb_response_generator;
  logic clk = 1'b0;
  logic reset, generate_ack, generate_nak, payload_valid, payload_ready;
  logic message_ready, message_data_valid, message_frame_valid;
  logic queue_full, overflow, overflow_clear;
  logic [7:0] eid_in, len_in, payload_data, message_data;
  logic [2:0] queue_count;

  response_generator dut (
    .clk(clk), .reset(reset), .generate_ack(generate_ack), .generate_nak(generate_nak),
    .eid_in(eid_in), .len_in(len_in), .payload_data(payload_data),
    .payload_valid(payload_valid), .payload_ready(payload_ready),
    .message_ready(message_ready), .message_data(message_data),
    .message_data_valid(message_data_valid), .message_frame_valid(message_frame_valid),
    .queue_count(queue_count), .queue_full(queue_full), .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0, frames = 0, rdy_mode = 0, f0;
  bit gap_en = 1'b0, xfer = 1'b0, prev_hold = 1'b0, prev_mfv = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for one cycle; accepted requests queue their expected bytes.
  task automatic send(input bit ack, input bit nak, input logic [7:0] eid,
                      input logic [7:0] len, input logic [7:0] base, input bit accept);
    generate_ack = ack;
    generate_nak = nak;
    eid_in = eid;
    len_in = len;
    if (accept) begin
      exp_q.push_back((nak && !ack) ? 8'h01 : 8'h00);
      exp_q.push_back(eid);
      exp_q.push_back(len);
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(base + 8'(i));
        pay_q.push_back(base + 8'(i));
      end
    end
    step();
    generate_ack = 1'b0;
    generate_nak = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !message_frame_valid && queue_count == 0) break;
    end
    chk(tag, exp_q.size(), 0);
    chk({tag, "_fv"}, message_frame_valid, 1'b0);
  endtask

  task automatic rst_chk();
    chk("rst_data", message_data, 8'h00);
    chk("rst_dv", message_data_valid, 1'b0);
    chk("rst_fv", message_frame_valid, 1'b0);
    chk("rst_pr", payload_ready, 1'b0);
    chk("rst_cnt", queue_count, 3'd0);
    chk("rst_full", queue_full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_mfv = 1'b0;
      xfer = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", message_data_valid, 1'b1);
        chk("hold_data", message_data, prev_data);
      end
      if (!message_data_valid) chk("idle_data", message_data, 8'h00);
      if (!message_frame_valid) chk("idle_pready", payload_ready, 1'b0);
      if (message_frame_valid && !prev_mfv) frames++;
      if (message_data_valid && message_ready) begin
        chk("byte_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("byte", message_data, exp_q.pop_front());
      end
      prev_hold = message_data_valid && !message_ready;
      prev_data = message_data;
      prev_mfv = message_frame_valid;
      xfer = payload_valid && payload_ready;
    end
  end

  // Ready pattern and payload source; payload holds steady until it transfers.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: message_ready = 1'b1;
      1: message_ready = ~message_ready;
      2: message_ready = 1'($urandom_range(0, 1));
      default: message_ready = 1'b0;
    endcase
    if (xfer && pay_q.size() != 0) pay_q.delete(0);
    if (!payload_valid || xfer || pay_q.size() == 0)
      payload_valid = (pay_q.size() != 0) && (!gap_en || $urandom_range(0, 2) != 0);
    payload_data = payload_valid ? pay_q[0] : 8'h00;
  end

  initial begin
    reset = 1'b1;
    generate_ack = 1'b1;
    generate_nak = 1'b0;
    eid_in = 8'hEE;
    len_in = 8'h00;
    overflow_clear = 1'b0;
    message_ready = 1'b1;
    payload_valid = 1'b0;
    payload_data = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    generate_ack = 1'b0;
    @(negedge clk);
    rst_chk();
    repeat (5) @(negedge clk);
    chk("no_frame_after_reset", frames, 0);

    // ACK, len 0: TYPE byte two cycles after the request
    step();
    f0 = frames;
    send(1, 0, 8'h5A, 8'd0, 8'h00, 1);
    @(negedge clk);
    chk("lat_fv_c1", message_frame_valid, 1'b0);
    chk("lat_cnt_c1", queue_count, 3'd1);
    @(negedge clk);
    chk("lat_fv_c2", message_frame_valid, 1'b1);
    chk("lat_dv_c2", message_data_valid, 1'b1);
    chk("lat_type_c2", message_data, 8'h00);
    wait_drain("ack_drain");
    chk("ack_frames", frames - f0, 1);

    // NAK with gapped payload and random ready
    rdy_mode = 2;
    gap_en = 1'b1;
    step();
    f0 = frames;
    send(0, 1, 8'h33, 8'd3, 8'hA1, 1);
    wait_drain("nak_drain");
    chk("nak_frames", frames - f0, 1);
    chk("nak_payload_left", pay_q.size(), 0);

    // Stall a frame in TYPE, then overfill the queue
    rdy_mode = 3;
    gap_en = 1'b0;
    step();
    f0 = frames;
    send(1, 0, 8'h77, 8'd0, 8'h00, 1);
    step();
    step();
    for (int i = 1; i <= 6; i++) send(1, 0, 8'(i), 8'd0, 8'h00, i <= 4);
    @(negedge clk);
    chk("ovf_full", queue_full, 1'b1);
    chk("ovf_cnt", queue_count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    step();
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 1'b0);
    step();
    overflow_clear = 1'b1;
    send(1, 0, 8'h99, 8'd0, 8'h00, 0);
    overflow_clear = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", overflow, 1'b1);
    chk("ovf_cnt_kept", queue_count, 3'd4);
    step();
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    rdy_mode = 0;
    wait_drain("ovf_drain");
    chk("ovf_frames", frames - f0, 5);

    // ACK and NAK together collapse to one ACK
    step();
    f0 = frames;
    send(1, 1, 8'h10, 8'd0, 8'h00, 1);
    @(negedge clk);
    chk("both_cnt", queue_count, 3'd1);
    chk("both_no_ovf", overflow, 1'b0);
    wait_drain("both_drain");
    chk("both_frames", frames - f0, 1);

    // Toggling ready: every byte held until accepted, one continuous frame
    rdy_mode = 1;
    step();
    f0 = frames;
    send(1, 0, 8'h42, 8'd2, 8'h90, 1);
    wait_drain("toggle_drain");
    chk("toggle_frames", frames - f0, 1);

    // Reset during PAYLOAD with two requests queued
    rdy_mode = 0;
    step();
    send(0, 1, 8'h55, 8'd5, 8'hC0, 1);
    send(1, 0, 8'h60, 8'd0, 8'h00, 1);
    send(1, 0, 8'h61, 8'd0, 8'h00, 1);
    begin : find_payload
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (payload_ready) disable find_payload;
      end
    end
    chk("mid_in_payload", payload_ready, 1'b1);
    chk("mid_queued", queue_count, 3'd2);
    #2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    pay_q.delete();
    @(negedge clk);
    rst_chk();
    f0 = frames;
    repeat (20) @(negedge clk);
    chk("mid_no_frames", frames - f0, 0);
    chk("mid_cnt", queue_count, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/response_generator.md
RESPONSE_GENERATOR -- requirements
Module: response_generator

Interface
REQ-001 SHALL provide parameter QUEUE_DEPTH, default 4, meaning the number of pending response requests held (power of two, >=2).
REQ-002 SHALL provide parameter CNT_W, default $clog2(QUEUE_DEPTH)+1, meaning the width of queue_count.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port generate_ack  input  1  single-cycle request to queue an ACK frame.
REQ-006 SHALL have port generate_nak  input  1  single-cycle request to queue a NAK frame.
REQ-007 SHALL have port eid_in  input  8  event ID, captured with the request.
REQ-008 SHALL have port len_in  input  8  payload byte count (0-255), captured with the request.
REQ-009 SHALL have port payload_data  input  8  payload byte stream.
REQ-010 SHALL have port payload_valid  input  1  payload_data is valid.
REQ-011 SHALL have port payload_ready  output  1  the block consumes payload_data this cycle.
REQ-012 SHALL have port message_ready  input  1  downstream accepts message_data this cycle.
REQ-013 SHALL have port message_data  output  8  frame byte.
REQ-014 SHALL have port message_data_valid  output  1  message_data is valid.
REQ-015 SHALL have port message_frame_valid  output  1  high for the entire frame.
REQ-016 SHALL have port queue_count  output  CNT_W  number of queued requests.
REQ-017 SHALL have port queue_full  output  1  queue_count == QUEUE_DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky flag: a request was dropped.
REQ-019 SHALL have port overflow_clear  input  1  clears overflow.

Function
REQ-020 SHALL enqueue {type, eid_in, len_in} on any edge where generate_ack or generate_nak is high and queue_full is low.
REQ-021 SHALL enqueue a single ACK entry when generate_ack and generate_nak are both high in the same cycle; the NAK is discarded and overflow is not set.
REQ-022 SHALL drop the request when queue_full is high at the edge, and SHALL set overflow; a same-edge pop does not make room.
REQ-023 SHALL let set win when overflow_clear and a drop occur in the same cycle.
REQ-024 SHALL use FSM states IDLE, TYPE, EID, LEN, PAYLOAD.
REQ-025 IDLE with queue non-empty: SHALL pop the head entry into internal registers and go to TYPE on the next edge; a push and a pop in the same cycle leave queue_count unchanged.
REQ-026 SHALL drive message_data 0x00 for ACK and 0x01 for NAK in TYPE, eid in EID, and len in LEN.
REQ-027 In TYPE, EID and LEN, message_data_valid SHALL be 1 and the state SHALL advance only on edges where message_ready is 1.
REQ-028 From LEN, SHALL go to IDLE if len==0, else to PAYLOAD with a byte counter loaded with len.
REQ-029 In PAYLOAD: message_data = payload_data; message_data_valid = payload_valid; payload_ready = message_ready; a byte transfers when payload_valid && message_ready, which decrements the counter.
REQ-030 SHALL go to IDLE on the edge where the last payload byte transfers.
REQ-031 SHALL hold message_frame_valid at 1 in TYPE through PAYLOAD and at 0 in IDLE, giving at least one idle cycle between frames.
REQ-032 Outside PAYLOAD, payload_ready SHALL be 0; outside a valid byte, message_data SHALL be 0x00.
REQ-033 Latency: with the queue empty, a request in cycle 0 with message_ready=1 SHALL produce the TYPE byte in cycle 2.
REQ-034 Held outputs (data, valid) SHALL remain stable while message_ready is 0.

Reset
REQ-035 On reset the block SHALL go to IDLE, flush the queue, and clear overflow, including when reset arrives mid-frame.
REQ-036 The cycle after reset, outputs SHALL be: message_data 0x00, message_data_valid 0, message_frame_valid 0, payload_ready 0, queue_count 0, queue_full 0, overflow 0.
REQ-037 Requests asserted during reset SHALL be ignored.

Verification
REQ-038 ACK with eid 0x5A, len 0, message_ready=1 -> cycles 2-4 show 00, 5A, 00 with both valids high, then frame_valid low.
REQ-039 NAK with eid 0x33, len 3, payload stream A1 A2 A3 (payload_valid gapped) -> 01, 33, 03, A1, A2, A3; payload_ready follows message_ready only in PAYLOAD; no byte lost or duplicated.
REQ-040 Six back-to-back ACKs (eid 1-6) while message_ready=0 -> queue_full after 4 queued, overflow=1, queue_count=4; after release, frames for eid 1-4 only, in order, each separated by >=1 IDLE cycle.
REQ-041 generate_ack and generate_nak both high, eid 0x10 -> exactly one frame, type byte 00; queue_count increments by 1.
REQ-042 message_ready toggled every cycle during an ACK frame -> each byte held stable until accepted; frame_valid continuous.
REQ-043 Reset asserted during the PAYLOAD of a len 5 frame with 2 requests queued -> next cycle all outputs at reset values, queue_count 0, no further frames emitted.
